// File: rtl/mem_rr_arbiter_if.sv
// Signal bundle between two requesters, the round-robin arbiter and one memory port.
// The arbiter uses the slave view; the requesters/memory side uses the master view.
interface mem_rr_arbiter_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
);
  logic                 r0Req;
  logic [AddrWidth-1:0] r0Addr;
  logic [DataWidth-1:0] r0WData;
  logic                 r0Write;
  logic                 r0Ack;
  logic [1:0]           r0Resp;
  logic [DataWidth-1:0] r0RData;

  logic                 r1Req;
  logic [AddrWidth-1:0] r1Addr;
  logic [DataWidth-1:0] r1WData;
  logic                 r1Write;
  logic                 r1Ack;
  logic [1:0]           r1Resp;
  logic [DataWidth-1:0] r1RData;

  logic                 memReq;
  logic [AddrWidth-1:0] memAddr;
  logic [DataWidth-1:0] memWData;
  logic                 memWrite;
  logic [1:0]           memResp;
  logic [DataWidth-1:0] memRData;

  modport slave (
    input  r0Req, r0Addr, r0WData, r0Write,
    output r0Ack, r0Resp, r0RData,
    input  r1Req, r1Addr, r1WData, r1Write,
    output r1Ack, r1Resp, r1RData,
    output memReq, memAddr, memWData, memWrite,
    input  memResp, memRData
  );

  modport master (
    output r0Req, r0Addr, r0WData, r0Write,
    input  r0Ack, r0Resp, r0RData,
    output r1Req, r1Addr, r1WData, r1Write,
    input  r1Ack, r1Resp, r1RData,
    input  memReq, memAddr, memWData, memWrite,
    output memResp, memRData
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory port, with a
// response timeout so a silent memory cannot stall either requester forever.
module mem_rr_arbiter #(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic            clk,
  input  logic            reset,
  mem_rr_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TimeoutLimit = 8'(TimeoutCycles);

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_last_grant;
  logic                 r_grant;
  logic [AddrWidth-1:0] r_addr;
  logic [DataWidth-1:0] r_wdata;
  logic                 r_write;
  logic [7:0]           r_cnt;

  logic                 r_mem_req;
  logic                 r_ack0;
  logic                 r_ack1;
  logic [1:0]           r_resp0;
  logic [1:0]           r_resp1;
  logic [DataWidth-1:0] r_rdata0;
  logic [DataWidth-1:0] r_rdata1;

  logic                 w_any_req;
  logic                 w_grant_idx;
  logic [7:0]           w_cnt_inc;
  logic                 w_resp_seen;
  logic                 w_timeout;
  logic                 w_finish;
  logic                 w_mem_req;
  logic [1:0]           w_code;
  logic [DataWidth-1:0] w_cap_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Arbitration, timeout detection and next-state decode
  always_comb begin
    w_any_req   = bus.r0Req | bus.r1Req;
    w_cnt_inc   = r_cnt + 8'd1;
    w_resp_seen = (bus.memResp != 2'b00);
    w_timeout   = (w_cnt_inc == TimeoutLimit);
    if (bus.r0Req && bus.r1Req) begin
      w_grant_idx = ~r_last_grant;
    end else if (bus.r1Req) begin
      w_grant_idx = 1'b1;
    end else begin
      w_grant_idx = 1'b0;
    end
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_next_state = BUSY;
        end else begin
          w_next_state = IDLE;
        end
      end
      BUSY: begin
        if (w_resp_seen || w_timeout) begin
          w_next_state = DONE;
        end else begin
          w_next_state = BUSY;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode; a real response takes precedence over a coincident timeout
  always_comb begin
    w_finish  = (r_state == BUSY) && (w_next_state == DONE);
    w_mem_req = (w_next_state == BUSY);
    if (w_resp_seen) begin
      w_code      = (bus.memResp == 2'b01) ? 2'b01 : 2'b10;
      w_cap_rdata = r_write ? '0 : bus.memRData;
    end else begin
      w_code      = 2'b11;
      w_cap_rdata = '0;
    end
  end

  // Request latch, grant history and BUSY cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_write      <= 1'b0;
      r_cnt        <= 8'd0;
    end else begin
      if ((r_state == IDLE) && w_any_req) begin
        r_grant      <= w_grant_idx;
        r_last_grant <= w_grant_idx;
        r_addr       <= w_grant_idx ? bus.r1Addr  : bus.r0Addr;
        r_wdata      <= w_grant_idx ? bus.r1WData : bus.r0WData;
        r_write      <= w_grant_idx ? bus.r1Write : bus.r0Write;
      end
      if ((r_state == BUSY) && !w_resp_seen) begin
        r_cnt <= w_cnt_inc;
      end else if (r_state == DONE) begin
        r_cnt <= 8'd0;
      end
    end
  end

  // Registered requester and memory outputs; ack fields are zero unless acking
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_req <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_resp0   <= 2'b00;
      r_resp1   <= 2'b00;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_mem_req <= w_mem_req;
      r_ack0    <= w_finish && !r_grant;
      r_ack1    <= w_finish && r_grant;
      r_resp0   <= (w_finish && !r_grant) ? w_code : 2'b00;
      r_resp1   <= (w_finish && r_grant) ? w_code : 2'b00;
      r_rdata0  <= (w_finish && !r_grant) ? w_cap_rdata : '0;
      r_rdata1  <= (w_finish && r_grant) ? w_cap_rdata : '0;
    end
  end

  assign bus.memReq   = r_mem_req;
  assign bus.memAddr  = r_addr;
  assign bus.memWData = r_wdata;
  assign bus.memWrite = r_write;
  assign bus.r0Ack    = r_ack0;
  assign bus.r0Resp   = r_resp0;
  assign bus.r0RData  = r_rdata0;
  assign bus.r1Ack    = r_ack1;
  assign bus.r1Resp   = r_resp1;
  assign bus.r1RData  = r_rdata1;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: directed vector table, corner-case
// sequences and a randomized run against a timestamp-based transaction model.
module tb_mem_rr_arbiter;
  localparam int T = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_rr_arbiter_if #(.DataWidth(32), .AddrWidth(32)) bus();

  mem_rr_arbiter #(.DataWidth(32), .AddrWidth(32), .TimeoutCycles(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        r0_req;
    logic        r1_req;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        wr0;
    logic        wr1;
    logic [1:0]  mresp;
    int          delay;
    logic [31:0] mrdata;
    int          exp_who;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_busy;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.r0Req = 1'b0; bus.r0Addr = 32'h0; bus.r0WData = 32'h0; bus.r0Write = 1'b0;
    bus.r1Req = 1'b0; bus.r1Addr = 32'h0; bus.r1WData = 32'h0; bus.r1Write = 1'b0;
    bus.memResp = 2'b00; bus.memRData = 32'h0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, " memReq"}, 32'(bus.memReq), 32'h0);
    chk({tag, " r0Ack"}, 32'(bus.r0Ack), 32'h0);
    chk({tag, " r1Ack"}, 32'(bus.r1Ack), 32'h0);
    chk({tag, " r0Resp"}, 32'(bus.r0Resp), 32'h0);
    chk({tag, " r1Resp"}, 32'(bus.r1Resp), 32'h0);
    chk({tag, " r0RData"}, bus.r0RData, 32'h0);
    chk({tag, " r1RData"}, bus.r1RData, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check_quiet(tag);
    chk({tag, " memAddr"}, bus.memAddr, 32'h0);
    chk({tag, " memWData"}, bus.memWData, 32'h0);
    chk({tag, " memWrite"}, 32'(bus.memWrite), 32'h0);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int   busy;
    logic done;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_wr;
    busy = 0;
    done = 1'b0;
    e_addr  = (v.exp_who == 1) ? v.addr1  : v.addr0;
    e_wdata = (v.exp_who == 1) ? v.wdata1 : v.wdata0;
    e_wr    = (v.exp_who == 1) ? v.wr1    : v.wr0;
    bus.r0Req = v.r0_req; bus.r0Addr = v.addr0; bus.r0WData = v.wdata0; bus.r0Write = v.wr0;
    bus.r1Req = v.r1_req; bus.r1Addr = v.addr1; bus.r1WData = v.wdata1; bus.r1Write = v.wr1;
    bus.memResp = 2'b00;
    tick();
    for (int s = 0; s < 20 && !done; s++) begin
      if (bus.r0Ack || bus.r1Ack) begin
        done = 1'b1;
      end else begin
        busy++;
        chk("vec memReq", 32'(bus.memReq), 32'h1);
        chk("vec memAddr", bus.memAddr, e_addr);
        chk("vec memWrite", 32'(bus.memWrite), 32'(e_wr));
        if (e_wr) chk("vec memWData", bus.memWData, e_wdata);
        if (busy == v.delay + 1) begin
          bus.memResp = v.mresp; bus.memRData = v.mrdata;
        end else begin
          bus.memResp = 2'b00; bus.memRData = $urandom;
        end
        tick();
      end
    end
    chk("vec ack within bound", 32'(done), 32'h1);
    chk("vec memReq at ack", 32'(bus.memReq), 32'h0);
    chk("vec r0Ack", 32'(bus.r0Ack), 32'(v.exp_who == 0));
    chk("vec r1Ack", 32'(bus.r1Ack), 32'(v.exp_who == 1));
    chk("vec r0Resp", 32'(bus.r0Resp), (v.exp_who == 0) ? 32'(v.exp_resp) : 32'h0);
    chk("vec r1Resp", 32'(bus.r1Resp), (v.exp_who == 1) ? 32'(v.exp_resp) : 32'h0);
    chk("vec r0RData", bus.r0RData, (v.exp_who == 0) ? v.exp_rdata : 32'h0);
    chk("vec r1RData", bus.r1RData, (v.exp_who == 1) ? v.exp_rdata : 32'h0);
    chk("vec busy cycles", 32'(busy), 32'(v.exp_busy));
    bus.r0Req = 1'b0; bus.r1Req = 1'b0; bus.memResp = 2'b00;
    tick();
    check_quiet("vec after ack");
  endtask

  task automatic run_random(input int ncyc);
    logic        act;
    logic        busy;
    logic        ackc;
    logic        pend0;
    logic        pend1;
    logic        t_wr;
    logic [1:0]  cin;
    logic [1:0]  t_code;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic [31:0] t_rdata;
    logic [31:0] rdin;
    int g, n, d, who, last;
    act = 1'b0; pend0 = 1'b0; pend1 = 1'b0; t_wr = 1'b0;
    cin = 2'b00; t_code = 2'b00; t_addr = 32'h0; t_wdata = 32'h0; t_rdata = 32'h0; rdin = 32'h0;
    g = 0; n = 0; d = 0; who = 0; last = 1;
    clear_inputs();
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      // Grant decision for the edge just taken, from the inputs present before it
      if ((!act || c >= g + n + 2) && (bus.r0Req || bus.r1Req)) begin
        who = (bus.r0Req && bus.r1Req) ? 1 - last : (bus.r1Req ? 1 : 0);
        last = who; act = 1'b1; g = c;
        t_addr  = (who == 1) ? bus.r1Addr  : bus.r0Addr;
        t_wdata = (who == 1) ? bus.r1WData : bus.r0WData;
        t_wr    = (who == 1) ? bus.r1Write : bus.r0Write;
        d = $urandom_range(0, 6);
        cin = 2'($urandom_range(1, 3));
        rdin = $urandom;
        if (d + 1 <= T) begin
          n = d + 1;
          t_code = (cin == 2'b01) ? 2'b01 : 2'b10;
          t_rdata = t_wr ? 32'h0 : rdin;
        end else begin
          n = T;
          t_code = 2'b11;
          t_rdata = 32'h0;
        end
      end
      busy = act && (c >= g) && (c < g + n);
      ackc = act && (c == g + n);
      chk("rnd memReq", 32'(bus.memReq), 32'(busy));
      if (busy) begin
        chk("rnd memAddr", bus.memAddr, t_addr);
        chk("rnd memWrite", 32'(bus.memWrite), 32'(t_wr));
        if (t_wr) chk("rnd memWData", bus.memWData, t_wdata);
      end
      chk("rnd r0Ack", 32'(bus.r0Ack), 32'(ackc && who == 0));
      chk("rnd r1Ack", 32'(bus.r1Ack), 32'(ackc && who == 1));
      chk("rnd r0Resp", 32'(bus.r0Resp), (ackc && who == 0) ? 32'(t_code) : 32'h0);
      chk("rnd r1Resp", 32'(bus.r1Resp), (ackc && who == 1) ? 32'(t_code) : 32'h0);
      chk("rnd r0RData", bus.r0RData, (ackc && who == 0) ? t_rdata : 32'h0);
      chk("rnd r1RData", bus.r1RData, (ackc && who == 1) ? t_rdata : 32'h0);
      if (busy && (c == g + d) && (d + 1 <= T)) begin
        bus.memResp = cin; bus.memRData = rdin;
      end else if (busy) begin
        bus.memResp = 2'b00; bus.memRData = $urandom;
      end else begin
        bus.memResp = 2'($urandom); bus.memRData = $urandom;
      end
      if (ackc && who == 0) begin
        bus.r0Req = 1'b0; pend0 = 1'b0;
      end else if (!pend0 && $urandom_range(0, 2) == 0) begin
        bus.r0Req = 1'b1; bus.r0Addr = $urandom; bus.r0WData = $urandom;
        bus.r0Write = 1'($urandom_range(0, 1)); pend0 = 1'b1;
      end else if (busy && who == 0 && $urandom_range(0, 1) == 1) begin
        bus.r0Addr = $urandom; bus.r0WData = $urandom; bus.r0Write = ~bus.r0Write;
      end
      if (ackc && who == 1) begin
        bus.r1Req = 1'b0; pend1 = 1'b0;
      end else if (!pend1 && $urandom_range(0, 2) == 0) begin
        bus.r1Req = 1'b1; bus.r1Addr = $urandom; bus.r1WData = $urandom;
        bus.r1Write = 1'($urandom_range(0, 1)); pend1 = 1'b1;
      end else if (busy && who == 1 && $urandom_range(0, 1) == 1) begin
        bus.r1Addr = $urandom; bus.r1WData = $urandom; bus.r1Write = ~bus.r1Write;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //            r0  r1   addr0      addr1      wdata0        wdata1        wr0   wr1   mresp  dly  mrdata        who resp   rdata         busy
    vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h200, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 2'b01, 2,  32'hDEADBEEF, 0, 2'b01, 32'hDEADBEEF, 3};
    vecs[1] = '{1'b0, 1'b1, 32'h300, 32'h40,  32'h33333333, 32'hCAFE0001, 1'b0, 1'b1, 2'b10, 0,  32'h12345678, 1, 2'b10, 32'h0,        1};
    vecs[2] = '{1'b1, 1'b0, 32'h500, 32'h600, 32'h0,        32'h0,        1'b0, 1'b0, 2'b00, 99, 32'hFFFFFFFF, 0, 2'b11, 32'h0,        4};
    vecs[3] = '{1'b1, 1'b1, 32'h700, 32'h800, 32'h0,        32'h0,        1'b0, 1'b0, 2'b11, 3,  32'h5A5A0F0F, 1, 2'b10, 32'h5A5A0F0F, 4};
    vecs[4] = '{1'b1, 1'b1, 32'h900, 32'hA00, 32'h77777777, 32'h88888888, 1'b1, 1'b1, 2'b01, 0,  32'hA5A5A5A5, 0, 2'b01, 32'h0,        1};
    vecs[5] = '{1'b0, 1'b1, 32'hB00, 32'hC00, 32'h0,        32'h0,        1'b0, 1'b0, 2'b01, 1,  32'h0BADF00D, 1, 2'b01, 32'h0BADF00D, 2};

    do_reset();
    check_all_zero("reset");
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Requester fields edited while BUSY must not reach the memory side
    bus.r0Req = 1'b1; bus.r0Addr = 32'h10; bus.r0Write = 1'b0;
    tick();
    for (int k = 1; k <= 3; k++) begin
      chk("stable memAddr", bus.memAddr, 32'h10);
      bus.r0Addr = 32'h20 + 32'(k);
      bus.memResp = (k == 3) ? 2'b01 : 2'b00;
      bus.memRData = 32'h600D0000;
      tick();
    end
    chk("stable r0Ack", 32'(bus.r0Ack), 32'h1);
    chk("stable r0RData", bus.r0RData, 32'h600D0000);
    bus.r0Req = 1'b0; bus.memResp = 2'b00;
    tick();

    // Both requesters held from reset alternate r0, r1, r0, r1
    do_reset();
    bus.r0Req = 1'b1; bus.r0Addr = 32'hA0;
    bus.r1Req = 1'b1; bus.r1Addr = 32'hB0;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("alt memReq", 32'(bus.memReq), 32'h1);
      chk("alt memAddr", bus.memAddr, (t % 2 == 0) ? 32'hA0 : 32'hB0);
      bus.memResp = 2'b01;
      tick();
      chk("alt r0Ack", 32'(bus.r0Ack), 32'(t % 2 == 0));
      chk("alt r1Ack", 32'(bus.r1Ack), 32'(t % 2 == 1));
      bus.memResp = 2'b00;
      tick();
    end
    bus.r0Req = 1'b0; bus.r1Req = 1'b0;
    tick();

    // Reset while BUSY drops the transaction and restores r0 priority
    bus.r0Req = 1'b1; bus.r0Addr = 32'hD0;
    tick();
    chk("rst grant memReq", 32'(bus.memReq), 32'h1);
    bus.r1Req = 1'b1; bus.r1Addr = 32'hE0;
    reset = 1'b1;
    tick();
    check_all_zero("mid reset");
    reset = 1'b0;
    tick();
    chk("post reset memReq", 32'(bus.memReq), 32'h1);
    chk("post reset memAddr", bus.memAddr, 32'hD0);
    bus.memResp = 2'b01; bus.memRData = 32'h13572468;
    tick();
    chk("post reset r0Ack", 32'(bus.r0Ack), 32'h1);
    chk("post reset r1Ack", 32'(bus.r1Ack), 32'h0);
    bus.memResp = 2'b00; bus.r0Req = 1'b0;
    tick();
    tick();
    chk("post reset r1 grant", bus.memAddr, 32'hE0);

    do_reset();
    run_random(1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
